// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC interrupt-acknowledge path.
package pic_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACK1 = 3'd1,
        GAP  = 3'd2,
        ACK2 = 3'd3,
        DONE = 3'd4
    } ack_state_t;

    localparam logic INTA_ACTIVE = 1'b0;
    localparam logic INTA_IDLE   = 1'b1;

    localparam int unsigned DEFAULT_PULSE_CYCLES = 2;
    localparam int unsigned DEFAULT_GAP_CYCLES   = 2;

    // Width of a down-counter able to hold the larger of the two phase lengths.
    function automatic int unsigned cnt_width(input int unsigned pulse, input int unsigned gap);
        return $clog2(((pulse > gap) ? pulse : gap) + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/int_ack_sequencer.sv
// CPU-side INTA initiator: issues the two acknowledge pulses to the PIC, captures
// the vector during the second pulse and hands it to the core over valid/ready.
module int_ack_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
    parameter int unsigned GAP_CYCLES   = DEFAULT_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       INT,
    input  logic       int_enable,
    input  logic [7:0] data_bus_in,
    output logic       int_ack,
    output logic       lock,
    output logic       busy,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ready,
    output logic       spurious
);

    localparam int unsigned CntW = cnt_width(PULSE_CYCLES, GAP_CYCLES);
    localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYCLES - 1);

    ack_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            int_s;
    logic            cnt_zero;
    logic            spurious_n_q;
    logic            spurious_q;
    logic [7:0]      vector_q;

    sync_2ff u_int_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (INT),
        .q_o   (int_s)
    );

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Once ACK1 is entered the pulse pair always completes; INT and int_enable
    // are only looked at in IDLE (INT again at the end of GAP for spurious).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (int_s && int_enable) begin
                    state_d = ACK1;
                    cnt_d   = PulseLoad;
                end
            end
            ACK1: begin
                if (cnt_zero) begin
                    state_d = GAP;
                    cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = ACK2;
                    cnt_d   = PulseLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK2: begin
                if (cnt_zero) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (vector_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spurious_n_q <= 1'b0;
            spurious_q   <= 1'b0;
            vector_q     <= 8'h00;
        end else begin
            if (state_q == GAP && cnt_zero) begin
                spurious_n_q <= int_s;
            end
            if (state_q == ACK2 && cnt_zero) begin
                vector_q   <= data_bus_in;
                spurious_q <= ~spurious_n_q;
            end
        end
    end

    always_comb begin
        int_ack      = INTA_IDLE;
        lock         = 1'b0;
        busy         = 1'b1;
        vector_valid = 1'b0;
        unique case (state_q)
            IDLE: busy = 1'b0;
            ACK1: begin
                int_ack = INTA_ACTIVE;
                lock    = 1'b1;
            end
            GAP: lock = 1'b1;
            ACK2: begin
                int_ack = INTA_ACTIVE;
                lock    = 1'b1;
            end
            DONE: vector_valid = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    assign vector   = vector_q;
    assign spurious = spurious_q;

endmodule

// File: tb/tb_int_ack_sequencer.sv
// Self-checking bench for int_ack_sequencer: default timing plus a PULSE=1/GAP=3 instance.
module tb_int_ack_sequencer;

    logic       clk = 1'b0;
    logic       reset, int_in, int_enable, vector_ready;
    logic [7:0] data_bus_in;
    logic       int_ack, lock, busy, vector_valid, spurious;
    logic [7:0] vector;

    logic       reset_b, int_b, en_b, ready_b;
    logic [7:0] data_b;
    logic       int_ack_b, lock_b, busy_b, valid_b, spurious_b;
    logic [7:0] vector_b;

    logic [8:0] sb_q[$];  // {spurious, vector}
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_ack_sequencer #(.PULSE_CYCLES(2), .GAP_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .INT          (int_in),
        .int_enable   (int_enable),
        .data_bus_in  (data_bus_in),
        .int_ack      (int_ack),
        .lock         (lock),
        .busy         (busy),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ready (vector_ready),
        .spurious     (spurious)
    );

    int_ack_sequencer #(.PULSE_CYCLES(1), .GAP_CYCLES(3)) dut_b (
        .clk          (clk),
        .reset        (reset_b),
        .INT          (int_b),
        .int_enable   (en_b),
        .data_bus_in  (data_b),
        .int_ack      (int_ack_b),
        .lock         (lock_b),
        .busy         (busy_b),
        .vector       (vector_b),
        .vector_valid (valid_b),
        .vector_ready (ready_b),
        .spurious     (spurious_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (int_ack === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reset_b = 1'b1;
        int_in = 1'b0; int_enable = 1'b0; vector_ready = 1'b0; data_bus_in = 8'h00;
        int_b = 1'b0; en_b = 1'b0; ready_b = 1'b0; data_b = 8'h00;
        tick(); tick();
        checks++;
        if ({int_ack, lock, busy, vector_valid, spurious, vector} !== {5'b10000, 8'h00}) begin
            errors++;
            $display("FAIL reset_a: ack/lock/busy/valid/spur=%b%b%b%b%b vec=%h, expected 10000 00",
                     int_ack, lock, busy, vector_valid, spurious, vector);
        end
        checks++;
        if ({int_ack_b, lock_b, busy_b, valid_b, spurious_b, vector_b} !== {5'b10000, 8'h00}) begin
            errors++;
            $display("FAIL reset_b: ack/lock/busy/valid/spur=%b%b%b%b%b vec=%h, expected 10000 00",
                     int_ack_b, lock_b, busy_b, valid_b, spurious_b, vector_b);
        end
        reset = 1'b0; reset_b = 1'b0;
        tick(); tick();
        checks++;
        if (int_ack !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: int_ack=%b busy=%b, expected 1 0", int_ack, busy);
        end
    endtask

    task automatic test_basic();
        bit ok;
        bit exp_ack[7]  = '{0, 0, 1, 1, 0, 0, 1};
        bit exp_lock[7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [8:0] exp;
        int_in = 1'b1; int_enable = 1'b1; vector_ready = 1'b1; data_bus_in = 8'h4A;
        sb_q.push_back({1'b0, 8'h4A});
        wait_ack(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_start: int_ack=%b, expected 0 within 10 cycles", int_ack);
        end
        int_enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            checks++;
            if (int_ack !== exp_ack[i] || lock !== exp_lock[i]) begin
                errors++;
                $display("FAIL basic_pattern[%0d]: int_ack=%b lock=%b, expected %b %b",
                         i, int_ack, lock, exp_ack[i], exp_lock[i]);
            end
        end
        checks++;
        if (vector_valid !== 1'b1 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL basic_valid: vector_valid=%b queue=%0d, expected 1 and entry",
                     vector_valid, sb_q.size());
        end else begin
            exp = sb_q.pop_front();
            if ({spurious, vector} !== exp) begin
                errors++;
                $display("FAIL basic_vector: spur/vec=%b/%h, expected %b/%h",
                         spurious, vector, exp[8], exp[7:0]);
            end
        end
        tick();
        checks++;
        if (vector_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_cycle: vector_valid=%b busy=%b, expected 0 0",
                     vector_valid, busy);
        end
    endtask

    task automatic test_disabled();
        bit bad = 1'b0;
        bit found = 1'b0;
        logic [8:0] exp;
        int_in = 1'b1; int_enable = 1'b0; vector_ready = 1'b1; data_bus_in = 8'h5C;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (int_ack !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL disabled_idle: int_ack=%b busy=%b, expected 1 0 throughout",
                     int_ack, busy);
        end
        int_enable = 1'b1;
        sb_q.push_back({1'b0, 8'h5C});
        tick();
        checks++;
        if (int_ack !== 1'b0 || lock !== 1'b1) begin
            errors++;
            $display("FAIL disabled_start: int_ack=%b lock=%b, expected 0 1", int_ack, lock);
        end
        int_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vector_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || sb_q.size() == 0) begin
            errors++;
            $display("FAIL disabled_valid: vector_valid=%b, expected 1 within 10 cycles",
                     vector_valid);
        end else begin
            exp = sb_q.pop_front();
            if ({spurious, vector} !== exp) begin
                errors++;
                $display("FAIL disabled_vector: spur/vec=%b/%h, expected %b/%h",
                         spurious, vector, exp[8], exp[7:0]);
            end
        end
        tick();
    endtask

    task automatic test_spurious();
        bit ok;
        bit exp_ack[7] = '{0, 0, 1, 1, 0, 0, 1};
        logic [8:0] exp;
        int_in = 1'b1; int_enable = 1'b1; vector_ready = 1'b1; data_bus_in = 8'h27;
        sb_q.push_back({1'b1, 8'h27});
        wait_ack(ok);
        int_in = 1'b0; int_enable = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL spur_start: int_ack=%b, expected 0 within 10 cycles", int_ack);
        end
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            checks++;
            if (int_ack !== exp_ack[i]) begin
                errors++;
                $display("FAIL spur_pattern[%0d]: int_ack=%b, expected %b",
                         i, int_ack, exp_ack[i]);
            end
        end
        checks++;
        if (vector_valid !== 1'b1 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL spur_valid: vector_valid=%b, expected 1", vector_valid);
        end else begin
            exp = sb_q.pop_front();
            if ({spurious, vector} !== exp) begin
                errors++;
                $display("FAIL spur_vector: spur/vec=%b/%h, expected %b/%h",
                         spurious, vector, exp[8], exp[7:0]);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        bit found = 1'b0;
        bit bad = 1'b0;
        logic [8:0] exp;
        int_in = 1'b1; int_enable = 1'b1; vector_ready = 1'b0; data_bus_in = 8'h3C;
        sb_q.push_back({1'b0, 8'h3C});
        wait_ack(ok);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vector_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || !found || sb_q.size() == 0) begin
            errors++;
            $display("FAIL bp_valid: started=%b valid=%b, expected 1 1", ok, vector_valid);
        end else begin
            exp = sb_q.pop_front();
            if ({spurious, vector} !== exp) begin
                errors++;
                $display("FAIL bp_vector: spur/vec=%b/%h, expected %b/%h",
                         spurious, vector, exp[8], exp[7:0]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vector_valid !== 1'b1 || vector !== 8'h3C || int_ack !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: valid=%b vec=%h int_ack=%b, expected 1 3c 1 throughout",
                     vector_valid, vector, int_ack);
        end
        vector_ready = 1'b1;
        sb_q.push_back({1'b0, 8'h3C});
        tick();
        checks++;
        if (vector_valid !== 1'b0 || busy !== 1'b0 || int_ack !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle_gap: valid=%b busy=%b int_ack=%b, expected 0 0 1",
                     vector_valid, busy, int_ack);
        end
        tick();
        checks++;
        if (int_ack !== 1'b0 || lock !== 1'b1) begin
            errors++;
            $display("FAIL bp_restart: int_ack=%b lock=%b, expected 0 1", int_ack, lock);
        end
        int_enable = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vector_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || sb_q.size() == 0) begin
            errors++;
            $display("FAIL bp_second: vector_valid=%b, expected 1 within 10 cycles",
                     vector_valid);
        end else begin
            exp = sb_q.pop_front();
            if ({spurious, vector} !== exp) begin
                errors++;
                $display("FAIL bp_second_vector: spur/vec=%b/%h, expected %b/%h",
                         spurious, vector, exp[8], exp[7:0]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int_in = 1'b1; int_enable = 1'b1; vector_ready = 1'b1; data_bus_in = 8'hE1;
        wait_ack(ok);
        int_enable = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (!ok || int_ack !== 1'b0 || lock !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack2: int_ack=%b lock=%b, expected 0 1", int_ack, lock);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({int_ack, lock, busy, vector_valid, vector} !== {4'b1000, 8'h00}) begin
            errors++;
            $display("FAIL mid_reset: ack/lock/busy/valid=%b%b%b%b vec=%h, expected 1000 00",
                     int_ack, lock, busy, vector_valid, vector);
        end
        tick();
        reset = 1'b0; int_in = 1'b0;
        tick(); tick();
        checks++;
        if (int_ack !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: int_ack=%b busy=%b, expected 1 0", int_ack, busy);
        end
    endtask

    task automatic test_sweep();
        bit ok = 1'b0;
        bit exp_ack[6]  = '{0, 1, 1, 1, 0, 1};
        bit exp_lock[6] = '{1, 1, 1, 1, 1, 0};
        logic [8:0] exp;
        int_b = 1'b1; en_b = 1'b1; ready_b = 1'b1; data_b = 8'h91;
        sb_q.push_back({1'b0, 8'h91});
        for (int i = 0; i < 10; i++) begin
            tick();
            if (int_ack_b === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        en_b = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sweep_start: int_ack=%b, expected 0 within 10 cycles", int_ack_b);
        end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            checks++;
            if (int_ack_b !== exp_ack[i] || lock_b !== exp_lock[i]) begin
                errors++;
                $display("FAIL sweep_pattern[%0d]: int_ack=%b lock=%b, expected %b %b",
                         i, int_ack_b, lock_b, exp_ack[i], exp_lock[i]);
            end
        end
        checks++;
        if (valid_b !== 1'b1 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL sweep_valid: vector_valid=%b, expected 1", valid_b);
        end else begin
            exp = sb_q.pop_front();
            if ({spurious_b, vector_b} !== exp) begin
                errors++;
                $display("FAIL sweep_vector: spur/vec=%b/%h, expected %b/%h",
                         spurious_b, vector_b, exp[8], exp[7:0]);
            end
        end
        tick();
        checks++;
        if (valid_b !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL sweep_done: valid=%b busy=%b, expected 0 0", valid_b, busy_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_disabled();
        test_spurious();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
